// File: rtl/gate_bist_pkg.sv
// Shared types, gate bit layout and golden function for the two-input gate BIST.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int GATE_W   = 8;

    localparam int IDX_NOTA = 7;
    localparam int IDX_NOTB = 6;
    localparam int IDX_AND  = 5;
    localparam int IDX_NAND = 4;
    localparam int IDX_OR   = 3;
    localparam int IDX_NOR  = 2;
    localparam int IDX_XOR  = 1;
    localparam int IDX_XNOR = 0;

    function automatic logic [GATE_W-1:0] gate_expect(input logic a, input logic b);
        logic [GATE_W-1:0] y;
        y           = '0;
        y[IDX_NOTA] = ~a;
        y[IDX_NOTB] = ~b;
        y[IDX_AND]  = a & b;
        y[IDX_NAND] = ~(a & b);
        y[IDX_OR]   = a | b;
        y[IDX_NOR]  = ~(a | b);
        y[IDX_XOR]  = a ^ b;
        y[IDX_XNOR] = ~(a ^ b);
        return y;
    endfunction

endpackage

// File: rtl/gate_bist_expect.sv
// Combinational golden model: expected gate outputs for the applied {a,b}.
module gate_bist_expect
    import gate_bist_pkg::*;
(
    input  logic              a_i,
    input  logic              b_i,
    output logic [GATE_W-1:0] exp_o
);

    assign exp_o = gate_expect(a_i, b_i);

endmodule

// File: rtl/gate_bist_checker.sv
// BIST controller: sweeps {a,b} over all four vectors, waits for settle, and
// checks the gate block outputs against the golden model.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              a_out,
    output logic              b_out,
    input  logic [GATE_W-1:0] gate_res,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [1:0]        fail_vec,
    output logic [GATE_W-1:0] fail_bits
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PC_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUM_PASSES - 1);

    state_e            state_q;
    logic [1:0]        vec_q;
    logic [SC_W-1:0]   scnt_q;
    logic [PC_W-1:0]   pcnt_q;
    logic [ERR_W-1:0]  err_q;
    logic [ERR_W-1:0]  err_d;
    logic [1:0]        fail_vec_q;
    logic [GATE_W-1:0] fail_bits_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic [GATE_W-1:0] exp_w;
    logic [GATE_W-1:0] diff_w;
    logic              mismatch_w;

    gate_bist_expect u_expect (
        .a_i   (vec_q[1]),
        .b_i   (vec_q[0]),
        .exp_o (exp_w)
    );

    // Case inequality so an X/Z from the gate block counts as a failure.
    assign mismatch_w = (gate_res !== exp_w);
    assign diff_w     = gate_res ^ exp_w;
    assign err_d      = (&err_q) ? err_q : err_q + ERR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            scnt_q      <= '0;
            pcnt_q      <= '0;
            err_q       <= '0;
            fail_vec_q  <= '0;
            fail_bits_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_SETTLE;
                        vec_q       <= '0;
                        scnt_q      <= '0;
                        pcnt_q      <= '0;
                        err_q       <= '0;
                        fail_vec_q  <= '0;
                        fail_bits_q <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (scnt_q == SC_LAST) begin
                        state_q <= ST_CHECK;
                    end else begin
                        scnt_q <= scnt_q + SC_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch_w) begin
                        err_q <= err_d;
                        // err_q never returns to zero once hit, so zero marks "no failure yet".
                        if (err_q == '0) begin
                            fail_vec_q  <= vec_q;
                            fail_bits_q <= diff_w;
                        end
                    end
                    if (vec_q == 2'd3 && pcnt_q == PC_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mismatch_w;
                    end else begin
                        state_q <= ST_SETTLE;
                        scnt_q  <= '0;
                        vec_q   <= vec_q + 2'd1;
                        if (vec_q == 2'd3) begin
                            pcnt_q <= pcnt_q + PC_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign a_out     = vec_q[1];
    assign b_out     = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_vec_q;
    assign fail_bits = fail_bits_q;

endmodule

// File: doc/gate_bist_checker.md
# gate_bist_checker

Sequential built-in self-test controller for the two-input all-gates unit. It sweeps the four input combinations of `a`/`b` into the gate block, waits a programmable settle time, and samples the eight gate outputs. Each sample is compared against a golden model, and the block reports mismatch count, first failing vector and pass/fail. It sits beside the gate block in the level-0 integration and takes the place of a simulation-only stimulus/monitor with synthesizable checking.

## Interface
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling; legal range ≥ 1.
- `NUM_PASSES`, default 1: full 4-vector sweeps per run; legal range ≥ 1.
- `ERR_W`, default 4: width of the error counter.

- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: run request, sampled in IDLE/DONE only.
- `a_out` out 1: `a` input driven to the gate block.
- `b_out` out 1: `b` input driven to the gate block.
- `gate_res` in 8: {ynota, ynotb, yand, ynand, yor, ynor, yxor, yxnor}, with bit 7 = ynota and bit 0 = yxnor.
- `busy` out 1: high in SETTLE/CHECK.
- `done` out 1: high in DONE, held until the next start.
- `pass` out 1: valid when `done`; 1 iff zero mismatches.
- `err_count` out ERR_W: mismatching vectors, saturating.
- `fail_vec` out 2: {a,b} of the first mismatching vector.
- `fail_bits` out 8: `gate_res` XOR expected at the first mismatch.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- Reset: state IDLE; all outputs 0.
- IDLE/DONE with `start`=1:
  - Next state SETTLE, with vec=0 and pass count=0.
  - {a_out,b_out}=0, settle count=0.
  - Clears err_count, fail_vec, fail_bits, pass and done.
- SETTLE: counts SETTLE_CYCLES cycles, then moves to CHECK. {a_out,b_out} are held constant.
- CHECK (one cycle): compares `gate_res` against the expected vector derived from the registered `a_out`/`b_out`:
  - Expected vector is {~a, ~b, a&b, ~(a&b), a|b, ~(a|b), a^b, ~(a^b)}.
  - Any bit differing, including X/Z, is a mismatch.
  - On a mismatch, err_count increments and saturates at 2^ERR_W−1.
  - On the first mismatch of the run only, fail_vec and fail_bits are captured.
- CHECK exit:
  - If vec=3 and pass count=NUM_PASSES−1: go to DONE, with pass = (no mismatch seen).
  - Otherwise: vec wraps 3→0 and increments the pass count, drives {a_out,b_out}=next vec, and returns to SETTLE.
- `start` in SETTLE/CHECK is ignored.
- DONE holds all results and {a_out,b_out} until `start` or `rst`.

## Timing
- Each vector occupies SETTLE_CYCLES+1 cycles. `a_out`/`b_out` change only on the edge leaving CHECK, or on the start edge.
- `done` rises 4·NUM_PASSES·(SETTLE_CYCLES+1) edges after the edge that samples `start`. With the defaults this is 8.
- `busy` rises on the start-sampling edge and falls on the edge `done` rises.
- Comparison uses `gate_res` sampled at the CHECK edge; the gate block must settle within SETTLE_CYCLES.
- Async `rst` mid-run aborts immediately: IDLE, all outputs 0, no partial results retained.
- Saturation: once err_count reaches 2^ERR_W−1 it holds; `pass` is still 0.

## Structure
- Package `gate_bist_pkg` holds:
  - the state enum;
  - `GATE_W`=8;
  - named bit-index constants (IDX_NOTA=7 … IDX_XNOR=0);
  - the function `gate_expect(a,b)` returning the 8-bit golden vector.
- One sub-module: `gate_bist_expect`, a combinational golden model wrapping `gate_expect`. It is instantiated once; the FSM, counters and capture registers stay in the top.

## Test plan
- Correct gate block, defaults, `start` pulse:
  - {a_out,b_out} steps 00,01,10,11, each held 2 cycles.
  - `done`=1 after 8 edges, with pass=1, err_count=0, fail_bits=0.
- yand stuck-at-0:
  - err_count=1, fail_vec=2'b11, fail_bits=8'b0010_0000.
  - pass=0.
- yxor/yxnor swapped:
  - err_count=4, fail_vec=2'b00, fail_bits=8'b0000_0011.
- `start` re-pulsed during vec 1 is ignored (done still at edge 8). Then `rst` asserted during vec 2 gives all outputs 0 immediately, and a new `start` completes cleanly with pass=1.
- NUM_PASSES=4, ERR_W=3, all gate outputs inverted:
  - 16 mismatches; err_count saturates at 7.
  - fail_vec=00, fail_bits=8'hFF, pass=0.
- SETTLE_CYCLES=3: each vector held 4 cycles; done at edge 16; pass=1.
